timing_state_generator: RTL and testbench

- Generates the one-hot instruction timing states T0..T5 for the 6502 core.
- The 6-input bubbled AND decode terms consume these states: each term matches opcode bits against a timing state.
- The block sits between the RDY/bus-control logic and the decode PLA. It also produces the SYNC marker, a jam indication and a saturating stall counter.

---
 rtl/timing_state_generator_pkg.sv | 41 ++++
 rtl/timing_state_generator_saturating_counter.sv | 24 ++
 rtl/timing_state_generator.sv | 74 +++++++
 tb/tb_timing_state_generator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_state_generator_pkg.sv
// Shared timing-state constants and encodings for the timing generator and the decode PLA.
// T0..T5 map to one-hot bits of T_State; the jam state drives all bits low.
package timing_state_generator_pkg;

  localparam int T_STATE_WIDTH = 6;
  localparam int T0_BIT = 0;
  localparam int T1_BIT = 1;
  localparam int T2_BIT = 2;
  localparam int T3_BIT = 3;
  localparam int T4_BIT = 4;
  localparam int T5_BIT = 5;

  localparam logic [T_STATE_WIDTH-1:0] T_STATE_RESET = 6'b000010;
  localparam logic [T_STATE_WIDTH-1:0] T_STATE_JAM   = 6'b000000;

  typedef enum logic [2:0] {
    ST_T0  = 3'd0,
    ST_T1  = 3'd1,
    ST_T2  = 3'd2,
    ST_T3  = 3'd3,
    ST_T4  = 3'd4,
    ST_T5  = 3'd5,
    ST_JAM = 3'd6
  } tstate_e;

  function automatic logic [T_STATE_WIDTH-1:0] state_onehot(input tstate_e s);
    logic [T_STATE_WIDTH-1:0] v;
    v = T_STATE_JAM;
    case (s)
      ST_T0:   v[T0_BIT] = 1'b1;
      ST_T1:   v[T1_BIT] = 1'b1;
      ST_T2:   v[T2_BIT] = 1'b1;
      ST_T3:   v[T3_BIT] = 1'b1;
      ST_T4:   v[T4_BIT] = 1'b1;
      ST_T5:   v[T5_BIT] = 1'b1;
      default: v = T_STATE_JAM;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/timing_state_generator_saturating_counter.sv
// Saturating up-counter with synchronous clear; Clear wins over Inc.
module timing_state_generator_saturating_counter #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Inc,
  input  logic             Clear,
  output logic [WIDTH-1:0] Count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      r_count <= '0;
    end else if (Inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign Count = r_count;

endmodule

// File: rtl/timing_state_generator.sv
// 6502 instruction timing-state sequencer: one-hot T0..T5, SYNC, jam detect and stall statistics.
// A stalled read cycle freezes the state and must not consume Last_Cycle.
module timing_state_generator
  import timing_state_generator_pkg::*;
#(
  parameter int StallCountBits = 8,
  parameter bit JamEnable      = 1'b1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Tick,
  input  logic                      Rdy,
  input  logic                      Rw,
  input  logic                      Last_Cycle,
  input  logic                      Clear_Stats,
  output logic [T_STATE_WIDTH-1:0]  T_State,
  output logic                      Sync,
  output logic                      Jam,
  output logic [StallCountBits-1:0] Stall_Count
);

  tstate_e                    r_state;
  tstate_e                    w_next;
  logic [T_STATE_WIDTH-1:0]   r_t_state;
  logic                       r_sync;
  logic                       r_jam;
  logic                       w_stall;
  logic                       w_advance;
  logic                       w_stall_inc;

  // NMOS behaviour: only read cycles honour RDY
  assign w_stall     = !Rdy && Rw;
  assign w_advance   = Tick && !w_stall && (r_state != ST_JAM);
  assign w_stall_inc = Tick &&  w_stall && (r_state != ST_JAM);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_T0:                      w_next = ST_T1;
      ST_T1, ST_T2, ST_T3, ST_T4: w_next = Last_Cycle ? ST_T0 : tstate_e'(r_state + 3'd1);
      ST_T5:                      w_next = (Last_Cycle || !JamEnable) ? ST_T0 : ST_JAM;
      default:                    w_next = ST_JAM;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= ST_T1;
      r_t_state <= T_STATE_RESET;
      r_sync    <= 1'b1;
      r_jam     <= 1'b0;
    end else if (w_advance) begin
      r_state   <= w_next;
      r_t_state <= state_onehot(w_next);
      r_sync    <= (w_next == ST_T1);
      r_jam     <= (w_next == ST_JAM);
    end
  end

  assign T_State = r_t_state;
  assign Sync    = r_sync;
  assign Jam     = r_jam;

  timing_state_generator_saturating_counter #(
    .WIDTH (StallCountBits)
  ) u_stall_count (
    .Clock (Clock),
    .Reset (Reset),
    .Inc   (w_stall_inc),
    .Clear (Clear_Stats),
    .Count (Stall_Count)
  );

endmodule

// File: tb/tb_timing_state_generator.sv
// Bench for timing_state_generator: directed scenarios plus randomized traffic against an integer-state model.
module tb_timing_state_generator;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Tick = 1'b0;
  logic       Rdy = 1'b1;
  logic       Rw = 1'b1;
  logic       Last_Cycle = 1'b0;
  logic       Clear_Stats = 1'b0;

  logic [5:0] t0, t1, t2;
  logic       s0, s1, s2;
  logic       j0, j1, j2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  int total = 0;
  int bad = 0;
  bit started = 0;

  // model: state 0..5 = Tn, 6 = jam; index 0 default, 1 no-jam, 2 two-bit counter
  int m_st[3];
  int m_cnt[3];

  always #5 Clock = ~Clock;

  timing_state_generator u_dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Rdy(Rdy), .Rw(Rw),
    .Last_Cycle(Last_Cycle), .Clear_Stats(Clear_Stats),
    .T_State(t0), .Sync(s0), .Jam(j0), .Stall_Count(c0));

  timing_state_generator #(.JamEnable(1'b0)) u_nojam (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Rdy(Rdy), .Rw(Rw),
    .Last_Cycle(Last_Cycle), .Clear_Stats(Clear_Stats),
    .T_State(t1), .Sync(s1), .Jam(j1), .Stall_Count(c1));

  timing_state_generator #(.StallCountBits(2)) u_sat2 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Rdy(Rdy), .Rw(Rw),
    .Last_Cycle(Last_Cycle), .Clear_Stats(Clear_Stats),
    .T_State(t2), .Sync(s2), .Jam(j2), .Stall_Count(c2));

  always @(posedge Clock) begin
    bit stalled;
    bit is_read_wait;
    for (int i = 0; i < 3; i++) begin
      if (Reset) begin
        m_st[i]  = 1;
        m_cnt[i] = 0;
      end else begin
        is_read_wait = !Rdy && Rw;
        stalled = Tick && is_read_wait && (m_st[i] != 6);
        if (Clear_Stats) m_cnt[i] = 0;
        else if (stalled && m_cnt[i] < ((i == 2) ? 3 : 255)) m_cnt[i] = m_cnt[i] + 1;
        if (Tick && !is_read_wait && m_st[i] != 6) begin
          if (m_st[i] == 0)      m_st[i] = 1;
          else if (Last_Cycle)   m_st[i] = 0;
          else if (m_st[i] == 5) m_st[i] = (i == 1) ? 0 : 6;
          else                   m_st[i] = m_st[i] + 1;
        end
      end
    end
  end

  function automatic logic [5:0] exp_t(input int st);
    if (st == 6) return 6'b000000;
    return 6'(1 << st);
  endfunction

  always @(negedge Clock) begin
    if (started) begin
      total++;
      if (!($onehot(t0) || (t0 == 6'b000000 && j0 === 1'b1))) begin
        bad++;
        $display("FAIL invariant t_state=%b jam=%b required=one-hot or zero-with-jam", t0, j0);
      end
    end
  end

  task automatic do_reset();
    Reset = 1'b1; Tick = 1'(($urandom)); Clear_Stats = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0; Tick = 1'b0;
  endtask

  task automatic tick_with(input bit rdy, input bit rw, input bit lc);
    Tick = 1'b1; Rdy = rdy; Rw = rw; Last_Cycle = lc;
    @(posedge Clock); #1;
    Tick = 1'b0;
  endtask

  task automatic test_reset();
    Tick = 1'b1; Rdy = 1'b0; Rw = 1'b1; Last_Cycle = 1'b1; Clear_Stats = 1'b1; Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0; Tick = 1'b0; Clear_Stats = 1'b0;
    started = 1'b1;
    total++; if (t0 !== 6'b000010) begin bad++; $display("FAIL reset_tstate got=%b want=000010", t0); end
    total++; if (s0 !== 1'b1) begin bad++; $display("FAIL reset_sync got=%b want=1", s0); end
    total++; if (j0 !== 1'b0) begin bad++; $display("FAIL reset_jam got=%b want=0", j0); end
    total++; if (c0 !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", c0); end
    total++; if (c2 !== 2'd0) begin bad++; $display("FAIL reset_count2 got=%0d want=0", c2); end
  endtask

  task automatic test_sequence();
    logic [5:0] seq[6];
    seq = '{6'b000010, 6'b000100, 6'b000001, 6'b000010, 6'b000100, 6'b000001};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      total++;
      if (t0 !== seq[k]) begin bad++; $display("FAIL seq_tstate[%0d] got=%b want=%b", k, t0, seq[k]); end
      total++;
      if (s0 !== ((k == 0 || k == 3) ? 1'b1 : 1'b0))
        begin bad++; $display("FAIL seq_sync[%0d] got=%b want=%b", k, s0, (k == 0 || k == 3)); end
      tick_with(1'b1, 1'b1, seq[k] == 6'b000100);
    end
  endtask

  task automatic test_two_cycle();
    logic [5:0] seq[4];
    seq = '{6'b000010, 6'b000001, 6'b000010, 6'b000001};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (t0 !== seq[k]) begin bad++; $display("FAIL two_cycle[%0d] got=%b want=%b", k, t0, seq[k]); end
      tick_with(1'b1, 1'b1, 1'b1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick_with(1'b1, 1'b1, 1'b0);
    tick_with(1'b1, 1'b1, 1'b0);
    total++; if (t0 !== 6'b001000) begin bad++; $display("FAIL stall_reach_t3 got=%b want=001000", t0); end
    for (int k = 0; k < 4; k++) begin
      tick_with(1'b0, 1'b1, 1'b1);
      total++; if (t0 !== 6'b001000) begin bad++; $display("FAIL stall_hold[%0d] got=%b want=001000", k, t0); end
      total++; if (c0 !== 8'(k + 1)) begin bad++; $display("FAIL stall_count[%0d] got=%0d want=%0d", k, c0, k + 1); end
    end
    tick_with(1'b1, 1'b1, 1'b0);
    total++; if (t0 !== 6'b010000) begin bad++; $display("FAIL stall_release got=%b want=010000", t0); end
    total++; if (c0 !== 8'd4) begin bad++; $display("FAIL stall_release_count got=%0d want=4", c0); end
    tick_with(1'b0, 1'b0, 1'b0);
    total++; if (t0 !== 6'b100000) begin bad++; $display("FAIL write_no_stall got=%b want=100000", t0); end
    total++; if (c0 !== 8'd4) begin bad++; $display("FAIL write_count got=%0d want=4", c0); end
  endtask

  task automatic test_jam();
    tick_with(1'b1, 1'b1, 1'b0);
    total++; if (t0 !== 6'b000000) begin bad++; $display("FAIL jam_tstate got=%b want=000000", t0); end
    total++; if (j0 !== 1'b1) begin bad++; $display("FAIL jam_flag got=%b want=1", j0); end
    total++; if (t1 !== 6'b000001) begin bad++; $display("FAIL nojam_wrap got=%b want=000001", t1); end
    total++; if (j1 !== 1'b0) begin bad++; $display("FAIL nojam_flag got=%b want=0", j1); end
    for (int k = 0; k < 10; k++) begin
      tick_with(1'($urandom), 1'($urandom), 1'($urandom));
      total++; if (t0 !== 6'b000000 || j0 !== 1'b1)
        begin bad++; $display("FAIL jam_hold[%0d] got=%b/%b want=000000/1", k, t0, j0); end
      total++; if (c0 !== 8'd4) begin bad++; $display("FAIL jam_count[%0d] got=%0d want=4", k, c0); end
    end
    do_reset();
    total++; if (t0 !== 6'b000010 || j0 !== 1'b0)
      begin bad++; $display("FAIL jam_exit got=%b/%b want=000010/0", t0, j0); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp2[5];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick_with(1'b0, 1'b1, 1'b0);
      total++; if (c2 !== exp2[k]) begin bad++; $display("FAIL sat2[%0d] got=%0d want=%0d", k, c2, exp2[k]); end
      total++; if (c0 !== 8'(k + 1)) begin bad++; $display("FAIL sat8[%0d] got=%0d want=%0d", k, c0, k + 1); end
      total++; if (s0 !== 1'b1 || t0 !== 6'b000010)
        begin bad++; $display("FAIL stall_t1_sync[%0d] got=%b/%b want=1/000010", k, s0, t0); end
    end
    Clear_Stats = 1'b1;
    tick_with(1'b0, 1'b1, 1'b0);
    Clear_Stats = 1'b0;
    total++; if (c2 !== 2'd0) begin bad++; $display("FAIL clear_wins2 got=%0d want=0", c2); end
    total++; if (c0 !== 8'd0) begin bad++; $display("FAIL clear_wins8 got=%0d want=0", c0); end
  endtask

  task automatic test_reset_tick0();
    do_reset();
    tick_with(1'b1, 1'b1, 1'b0);
    tick_with(1'b1, 1'b1, 1'b0);
    tick_with(1'b1, 1'b1, 1'b0);
    tick_with(1'b0, 1'b1, 1'b0);
    tick_with(1'b0, 1'b1, 1'b0);
    total++; if (t0 !== 6'b010000 || c0 !== 8'd2)
      begin bad++; $display("FAIL pre_reset got=%b/%0d want=010000/2", t0, c0); end
    Tick = 1'b0; Rdy = 1'b0; Rw = 1'b1; Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    total++; if (t0 !== 6'b000010 || s0 !== 1'b1 || c0 !== 8'd0)
      begin bad++; $display("FAIL reset_no_tick got=%b/%b/%0d want=000010/1/0", t0, s0, c0); end
    tick_with(1'b1, 1'b1, 1'b0);
    tick_with(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      Tick = 1'b0; Rdy = 1'($urandom); Rw = 1'($urandom); Last_Cycle = 1'($urandom);
      @(posedge Clock); #1;
      total++; if (t0 !== 6'b000100 || c0 !== 8'd1)
        begin bad++; $display("FAIL tick0_hold[%0d] got=%b/%0d want=000100/1", k, t0, c0); end
    end
  endtask

  task automatic test_random();
    logic [5:0] gt[3];
    logic       gs[3];
    logic       gj[3];
    int         gc[3];
    do_reset();
    for (int n = 0; n < 600; n++) begin
      Reset       = ($urandom % 50) == 0;
      Tick        = ($urandom % 4) != 0;
      Rdy         = ($urandom % 3) != 0;
      Rw          = 1'($urandom);
      Last_Cycle  = ($urandom % 3) == 0;
      Clear_Stats = ($urandom % 40) == 0;
      @(posedge Clock); #1;
      gt = '{t0, t1, t2}; gs = '{s0, s1, s2}; gj = '{j0, j1, j2};
      gc = '{int'(c0), int'(c1), int'(c2)};
      for (int i = 0; i < 3; i++) begin
        total++; if (gt[i] !== exp_t(m_st[i]))
          begin bad++; $display("FAIL rnd_tstate[%0d] n=%0d got=%b want=%b", i, n, gt[i], exp_t(m_st[i])); end
        total++; if (gs[i] !== (m_st[i] == 1))
          begin bad++; $display("FAIL rnd_sync[%0d] n=%0d got=%b want=%b", i, n, gs[i], (m_st[i] == 1)); end
        total++; if (gj[i] !== (m_st[i] == 6))
          begin bad++; $display("FAIL rnd_jam[%0d] n=%0d got=%b want=%b", i, n, gj[i], (m_st[i] == 6)); end
        total++; if (gc[i] != m_cnt[i])
          begin bad++; $display("FAIL rnd_count[%0d] n=%0d got=%0d want=%0d", i, n, gc[i], m_cnt[i]); end
      end
    end
    Reset = 1'b0; Tick = 1'b0; Clear_Stats = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_sequence();
    test_two_cycle();
    test_stall();
    test_jam();
    test_saturate();
    test_reset_tick0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
